// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of the single register-file write port
// among the execution units, plus the register scoreboard (reg_busy).
module wb_arbiter #(
    parameter int NREQ = 5,
    parameter int DW   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      wb_req,
    input  logic [7*NREQ-1:0]    wb_rn,
    input  logic [DW*NREQ-1:0]   wb_data,
    output logic [NREQ-1:0]      wb_ack,
    output logic                 rf_we,
    output logic [5:0]           rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic                 set_en,
    input  logic [6:0]           set_rn,
    input  logic                 set2_en,
    input  logic [6:0]           set2_rn,
    output logic [63:0]          reg_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [6:0]      req_rn   [NREQ];
    logic [DW-1:0]   req_data [NREQ];
    logic [NREQ-1:0] eligible;

    logic [NREQ-1:0] wb_ack_reg;
    logic [NREQ-1:0] wb_ack_next;
    logic            rf_we_reg;
    logic [5:0]      rf_waddr_reg;
    logic [DW-1:0]   rf_wdata_reg;
    logic [63:0]     busy_reg;
    logic [63:0]     busy_next;
    logic [PW-1:0]   last_grant_reg;

    logic            grant_valid;
    logic [PW-1:0]   grant_idx;
    logic [6:0]      win_rn;
    logic [DW-1:0]   win_data;
    logic            win_we;
    logic            set_ok;
    logic            set2_ok;

    // A unit whose ack is high this cycle is masked so a held request is not granted twice.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign req_rn[gi]   = wb_rn[7*gi +: 7];
            assign req_data[gi] = wb_data[DW*gi +: DW];
            assign eligible[gi] = wb_req[gi] & ~wb_ack_reg[gi];
        end
    endgenerate

    always_comb begin
        int idx;
        logic [PW-1:0] idx_sel;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx     = (int'(last_grant_reg) + 1 + k) % NREQ;
            idx_sel = PW'(idx);
            if (!grant_valid && eligible[idx_sel]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_sel;
            end
        end
    end

    assign win_rn   = req_rn[grant_idx];
    assign win_data = req_data[grant_idx];
    assign win_we   = grant_valid & ~win_rn[6] & (win_rn[5:0] != 6'd0);
    assign set_ok   = set_en  & ~set_rn[6]  & (set_rn[5:0]  != 6'd0);
    assign set2_ok  = set2_en & ~set2_rn[6] & (set2_rn[5:0] != 6'd0);

    always_comb begin
        wb_ack_next = '0;
        if (grant_valid) begin
            wb_ack_next[grant_idx] = 1'b1;
        end
    end

    // Sets are applied after the clear: a newly issued producer keeps the register busy.
    always_comb begin
        busy_next = busy_reg;
        if (win_we) begin
            busy_next[win_rn[5:0]] = 1'b0;
        end
        if (set_ok) begin
            busy_next[set_rn[5:0]] = 1'b1;
        end
        if (set2_ok) begin
            busy_next[set2_rn[5:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_reg     <= '0;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
            busy_reg       <= '0;
            last_grant_reg <= PW'(NREQ - 1);
        end else begin
            wb_ack_reg <= wb_ack_next;
            rf_we_reg  <= win_we;
            busy_reg   <= busy_next;
            if (grant_valid) begin
                last_grant_reg <= grant_idx;
                rf_waddr_reg   <= win_rn[5:0];
                rf_wdata_reg   <= win_data;
            end
        end
    end

    assign wb_ack   = wb_ack_reg;
    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign reg_busy = busy_reg;

endmodule
